wb_commit: RTL and testbench
============================

// Module: wb_commit
// PURPOSE
//  Writeback/commit end of the MEM->WB interface: consumes the registered wb_ctrl bundle and
//  is_last_in_block, and turns each instruction into architectural effects.
//  Effects: regfile write, LLbit update, CSR write, exception report and refetch.
//  Owns the LLbit register and the commit-side flush FSM.
//  Drives flush to every pipeline register and the redirect request to the frontend.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush_o is held after an exception or refetch (>=1)
//  EXCP_NUM_W    16  width of excp_num vector from the MEM stage
//  CNT_W         64  width of difftest cycle/instret counters
// PORTS
//  clk                input   1      pipeline clock
//  rst                input   1      asynchronous, active-low reset
//  wb_ctrl_i          input   struct wb_ctrl bundle from MEM->WB register
//  is_last_in_block_i input   1      committed instr ends a fetch block
//  reg_we_o           output  1      regfile write enable
//  reg_waddr_o        output  5      regfile write address
//  reg_wdata_o        output  32     regfile write data
//  llbit_o            output  1      current LLbit value (to EXE for SC)
//  csr_we_o           output  1      CSR write enable (from csr_signal_o)
//  csr_signal_o       output  struct CSR write addr/data
//  excp_o             output  1      one-cycle exception report to CSR unit
//  excp_ecode_o       output  6      encoded ecode of reported exception
//  excp_pc_o          output  32     PC of excepting instruction
//  flush_o            output  1      pipeline flush
//  refetch_o          output  1      one-cycle frontend redirect request
//  refetch_pc_o       output  32     redirect PC (excp: 0, CSR supplies target; refetch: pc+4)
//  block_commit_o     output  1      frontend block-commit pulse
//  busy_o             output  1      high in any non-IDLE state
// BEHAVIOUR
//  - Reset: every output 0, LLbit 0, FSM IDLE, counters 0; reset mid-flush aborts to IDLE.
//  - commit = wb_ctrl_i.valid & diff_commit_o.valid & state==IDLE. All effects are
//    registered; 1-cycle latency from wb_ctrl_i to outputs.
//  - Normal commit (no excp, no fetch_flush):
//    - reg_* <= wb_reg_o, gated by we.
//    - csr_* <= csr_signal_o.
//    - LLbit <= llbit_o.value if llbit_o.we.
//    - block_commit_o <= is_last_in_block_i.
//  - Exception (commit & excp):
//    - No reg/CSR/LLbit write; LLbit cleared.
//    - excp_o pulses 1 cycle; excp_pc_o = pc.
//    - ecode = EXCP_ECODE[lowest set index of excp_num] (index 0 = highest priority).
//    - excp with excp_num==0 -> ecode 6'h3F (internal error).
//    - FSM -> FLUSH.
//  - Refetch (commit & fetch_flush & !excp):
//    - Instruction's own writes commit.
//    - refetch_o pulses; refetch_pc_o = pc+4 (mod 2^32 wrap).
//    - FSM -> FLUSH.
//  - excp and fetch_flush on the same instr: exception wins, no refetch.
//  - FSM states and transitions:
//    - IDLE --excp|refetch--> FLUSH.
//    - FLUSH: flush_o=1 and a down-counter loaded with FLUSH_CYCLES-1; at 0 -> DRAIN.
//    - DRAIN: one cycle, drops any valid wb_ctrl_i still in flight; -> IDLE.
//  - Non-IDLE: incoming valids are ignored (no commit, no pulses); busy_o=1.
//  - Pulses (excp_o, refetch_o, block_commit_o) are never held >1 cycle.
// CONFIGURATION
//  DIFFTEST_COMMIT_EN defined:
//    - adds registered diff_* outputs (pc, instr, valid, ld/st en, addrs, st_data, excp, ecode).
//    - adds cycle_cnt_o and instret_o (CNT_W).
//    - cycle_cnt increments every cycle; instret increments on every non-excepting commit.
//    - both wrap at 2^CNT_W.
//  Undefined: none of those ports or registers exist; core behaviour unchanged.
// STRUCTURE
//  - Package entries: wb_ctrl, csr_write_signal, commit_state_t enum {IDLE,FLUSH,DRAIN},
//    EXCP_ECODE localparam table, ECODE_INTERNAL=6'h3F.
//  - Sub-module excp_prio_enc: EXCP_NUM_W -> {found, idx} lowest-set-bit encoder,
//    purely combinational.
// TESTING
//  - Commit pc=0x1c000000, we=1, waddr=5, wdata=0xDEAD -> next cycle reg_we_o=1,
//    waddr 5, wdata 0xDEAD, no flush.
//  - LL: llbit we=1 val=1 -> llbit_o=1.
//    Then excp_num=16'h0010 -> excp_o pulse, ecode=EXCP_ECODE[4], llbit_o=0, reg_we_o=0,
//    flush_o high 2 cycles.
//  - excp_num=16'h8001 -> ecode=EXCP_ECODE[0].
//    excp=1 with excp_num=0 -> ecode 6'h3F.
//  - fetch_flush=1 at pc=0xFFFFFFFC, we=1 -> reg write occurs, refetch_o pulse,
//    refetch_pc_o=0x0, valids during FLUSH/DRAIN ignored.
//  - excp & fetch_flush same instr -> excp_o=1, refetch_o=0.
//    Assert rst low during FLUSH -> all outputs 0, IDLE next edge.
//  - DIFFTEST_COMMIT_EN: 10 commits incl. 2 excepting -> instret_o=8,
//    cycle_cnt_o equals elapsed cycles.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback/commit stage.
// The DIFFTEST_COMMIT_EN build of wb_commit uses the diff_commit_o bundle fields below.
package wb_commit_pkg;

  localparam int EXCP_NUM_W_DEF = 16;

  // Reported when excp is raised but no excp_num bit says why.
  localparam logic [5:0] ECODE_INTERNAL = 6'h3F;

  // Exception code per excp_num bit; index 0 has the highest priority.
  localparam logic [5:0] EXCP_ECODE [EXCP_NUM_W_DEF] = '{
    6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
    6'h12, 6'h3E, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h05
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } commit_state_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_reg_t;

  typedef struct packed {
    logic we;
    logic value;
  } llbit_write_t;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [31:0] data;
  } csr_write_signal;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [7:0]  ld_en;
    logic [7:0]  st_en;
    logic [31:0] ld_vaddr;
    logic [31:0] st_paddr;
    logic [31:0] st_data;
  } diff_commit_t;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               pc;
    logic                      excp;
    logic [EXCP_NUM_W_DEF-1:0] excp_num;
    logic                      fetch_flush;
    wb_reg_t                   wb_reg_o;
    llbit_write_t              llbit_o;
    csr_write_signal           csr_signal_o;
    diff_commit_t              diff_commit_o;
  } wb_ctrl;

endpackage

// File: rtl/excp_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 is the most urgent exception cause.
module excp_prio_enc #(
  parameter int W     = 16,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last to overwrite idx.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: turns each committed instruction into architectural
// effects, owns the LLbit and the post-exception/refetch flush sequence.
// Optional feature macro: DIFFTEST_COMMIT_EN (difftest trace ports and counters).
//
// Handshake: an instruction is taken when wb_ctrl_i.valid and
// wb_ctrl_i.diff_commit_o.valid are both high while the FSM is IDLE; there is no
// backpressure, so anything offered while busy_o is high is dropped.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int EXCP_NUM_W   = EXCP_NUM_W_DEF,
  parameter int CNT_W        = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  wb_ctrl          wb_ctrl_i,
  input  logic            is_last_in_block_i,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic [31:0]     reg_wdata_o,
  output logic            llbit_o,
  output logic            csr_we_o,
  output csr_write_signal csr_signal_o,
  output logic            excp_o,
  output logic [5:0]      excp_ecode_o,
  output logic [31:0]     excp_pc_o,
  output logic            flush_o,
  output logic            refetch_o,
  output logic [31:0]     refetch_pc_o,
  output logic            block_commit_o,
  output logic            busy_o,
  output logic [1:0]      state_dbg_o
`ifdef DIFFTEST_COMMIT_EN
  ,
  output logic [31:0]     diff_pc_o,
  output logic [31:0]     diff_instr_o,
  output logic            diff_valid_o,
  output logic [7:0]      diff_ld_en_o,
  output logic [7:0]      diff_st_en_o,
  output logic [31:0]     diff_ld_vaddr_o,
  output logic [31:0]     diff_st_paddr_o,
  output logic [31:0]     diff_st_data_o,
  output logic            diff_excp_o,
  output logic [5:0]      diff_ecode_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o
`endif
);

  localparam int IDX_W = $clog2(EXCP_NUM_W);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  commit_state_t   state_q, state_d;
  logic [FC_W-1:0] cnt_q, cnt_d;

  logic             excp_found;
  logic [IDX_W-1:0] excp_idx;
  logic [5:0]       ecode_sel;

  logic commit, take_excp, take_refetch, retire, plain;
  logic do_reg;

  assign commit       = wb_ctrl_i.valid & wb_ctrl_i.diff_commit_o.valid & (state_q == IDLE);
  assign take_excp    = commit & wb_ctrl_i.excp;
  assign take_refetch = commit & wb_ctrl_i.fetch_flush & ~wb_ctrl_i.excp;
  assign retire       = commit & ~wb_ctrl_i.excp;
  assign plain        = retire & ~wb_ctrl_i.fetch_flush;
  assign do_reg       = retire & wb_ctrl_i.wb_reg_o.we;

  excp_prio_enc #(.W(EXCP_NUM_W), .IDX_W(IDX_W)) u_prio (
    .req   (wb_ctrl_i.excp_num),
    .found (excp_found),
    .idx   (excp_idx)
  );

  assign ecode_sel = excp_found ? EXCP_ECODE[excp_idx] : ECODE_INTERNAL;

  assign flush_o     = (state_q == FLUSH);
  assign busy_o      = (state_q != IDLE);
  assign state_dbg_o = state_q;

  // Flush FSM state and hold-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: hold FLUSH for FLUSH_CYCLES cycles, then one DRAIN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take_excp | take_refetch) begin
          state_d = FLUSH;
          cnt_d   = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = DRAIN;
        else             cnt_d   = cnt_q - FC_W'(1);
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Architectural writes of a non-excepting commit (refetching instructions included).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_we_o       <= 1'b0;
      reg_waddr_o    <= '0;
      reg_wdata_o    <= '0;
      csr_we_o       <= 1'b0;
      csr_signal_o   <= '0;
      block_commit_o <= 1'b0;
    end else begin
      reg_we_o       <= do_reg;
      reg_waddr_o    <= do_reg ? wb_ctrl_i.wb_reg_o.waddr : 5'd0;
      reg_wdata_o    <= do_reg ? wb_ctrl_i.wb_reg_o.wdata : 32'd0;
      csr_we_o       <= retire & wb_ctrl_i.csr_signal_o.we;
      csr_signal_o   <= retire ? wb_ctrl_i.csr_signal_o : '0;
      block_commit_o <= plain & is_last_in_block_i;
    end
  end

  // LLbit: an exception always clears it, otherwise the instruction may set/clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                llbit_o <= 1'b0;
    else if (take_excp)                      llbit_o <= 1'b0;
    else if (retire & wb_ctrl_i.llbit_o.we)  llbit_o <= wb_ctrl_i.llbit_o.value;
  end

  // One-cycle exception and refetch reports; exception wins when both are flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      excp_o       <= 1'b0;
      excp_ecode_o <= '0;
      excp_pc_o    <= '0;
      refetch_o    <= 1'b0;
      refetch_pc_o <= '0;
    end else begin
      excp_o       <= take_excp;
      excp_ecode_o <= take_excp ? ecode_sel : 6'd0;
      excp_pc_o    <= take_excp ? wb_ctrl_i.pc : 32'd0;
      refetch_o    <= take_refetch;
      refetch_pc_o <= take_refetch ? (wb_ctrl_i.pc + 32'd4) : 32'd0;
    end
  end

`ifdef DIFFTEST_COMMIT_EN
  // Difftest trace of each taken instruction plus free-running counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff_pc_o       <= '0;
      diff_instr_o    <= '0;
      diff_valid_o    <= 1'b0;
      diff_ld_en_o    <= '0;
      diff_st_en_o    <= '0;
      diff_ld_vaddr_o <= '0;
      diff_st_paddr_o <= '0;
      diff_st_data_o  <= '0;
      diff_excp_o     <= 1'b0;
      diff_ecode_o    <= '0;
      cycle_cnt_o     <= '0;
      instret_o       <= '0;
    end else begin
      diff_pc_o       <= commit ? wb_ctrl_i.pc : 32'd0;
      diff_instr_o    <= commit ? wb_ctrl_i.diff_commit_o.instr : 32'd0;
      diff_valid_o    <= retire;
      diff_ld_en_o    <= retire ? wb_ctrl_i.diff_commit_o.ld_en : 8'd0;
      diff_st_en_o    <= retire ? wb_ctrl_i.diff_commit_o.st_en : 8'd0;
      diff_ld_vaddr_o <= retire ? wb_ctrl_i.diff_commit_o.ld_vaddr : 32'd0;
      diff_st_paddr_o <= retire ? wb_ctrl_i.diff_commit_o.st_paddr : 32'd0;
      diff_st_data_o  <= retire ? wb_ctrl_i.diff_commit_o.st_data : 32'd0;
      diff_excp_o     <= take_excp;
      diff_ecode_o    <= take_excp ? ecode_sel : 6'd0;
      cycle_cnt_o     <= cycle_cnt_o + CNT_W'(1);
      instret_o       <= instret_o + CNT_W'(retire);
    end
  end
`else
  // Trace-only bundle fields have no consumer in this build.
  logic unused_diff;
  assign unused_diff = ^{wb_ctrl_i.diff_commit_o.instr, wb_ctrl_i.diff_commit_o.ld_en,
                         wb_ctrl_i.diff_commit_o.st_en, wb_ctrl_i.diff_commit_o.ld_vaddr,
                         wb_ctrl_i.diff_commit_o.st_paddr, wb_ctrl_i.diff_commit_o.st_data};
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios plus a randomized run
// against a cycle-count model of the commit/flush behaviour.
module tb_wb_commit;
  import wb_commit_pkg::*;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 64;

  logic            clk;
  logic            rst;
  wb_ctrl          wb_ctrl_i;
  logic            is_last_in_block_i;
  logic            reg_we_o;
  logic [4:0]      reg_waddr_o;
  logic [31:0]     reg_wdata_o;
  logic            llbit_o;
  logic            csr_we_o;
  csr_write_signal csr_signal_o;
  logic            excp_o;
  logic [5:0]      excp_ecode_o;
  logic [31:0]     excp_pc_o;
  logic            flush_o;
  logic            refetch_o;
  logic [31:0]     refetch_pc_o;
  logic            block_commit_o;
  logic            busy_o;
  logic [1:0]      state_dbg_o;
`ifdef DIFFTEST_COMMIT_EN
  logic [31:0] diff_pc_o, diff_instr_o, diff_ld_vaddr_o, diff_st_paddr_o, diff_st_data_o;
  logic        diff_valid_o, diff_excp_o;
  logic [7:0]  diff_ld_en_o, diff_st_en_o;
  logic [5:0]  diff_ecode_o;
  logic [CNT_W-1:0] cycle_cnt_o, instret_o;
`endif

  int checks;
  int failures;

  // Reference model state: cycles still blocked after a flush event, and the LLbit.
  int   blocked;
  logic model_llbit;

  wb_commit #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wb_ctrl_i(wb_ctrl_i), .is_last_in_block_i(is_last_in_block_i),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .llbit_o(llbit_o), .csr_we_o(csr_we_o), .csr_signal_o(csr_signal_o),
    .excp_o(excp_o), .excp_ecode_o(excp_ecode_o), .excp_pc_o(excp_pc_o),
    .flush_o(flush_o), .refetch_o(refetch_o), .refetch_pc_o(refetch_pc_o),
    .block_commit_o(block_commit_o), .busy_o(busy_o), .state_dbg_o(state_dbg_o)
`ifdef DIFFTEST_COMMIT_EN
    , .diff_pc_o(diff_pc_o), .diff_instr_o(diff_instr_o), .diff_valid_o(diff_valid_o),
    .diff_ld_en_o(diff_ld_en_o), .diff_st_en_o(diff_st_en_o), .diff_ld_vaddr_o(diff_ld_vaddr_o),
    .diff_st_paddr_o(diff_st_paddr_o), .diff_st_data_o(diff_st_data_o),
    .diff_excp_o(diff_excp_o), .diff_ecode_o(diff_ecode_o),
    .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wb_ctrl mk_commit(input logic [31:0] pc);
    wb_ctrl c;
    c = '0;
    c.valid = 1'b1;
    c.diff_commit_o.valid = 1'b1;
    c.pc = pc;
    return c;
  endfunction

  // Expected ecode from the priority rule: first set bit from index 0 upward.
  function automatic logic [5:0] ref_ecode(input logic [EXCP_NUM_W_DEF-1:0] num);
    for (int i = 0; i < EXCP_NUM_W_DEF; i++)
      if (num[i]) return EXCP_ECODE[i];
    return 6'h3F;
  endfunction

  // Driver: apply inputs at a falling edge, return at the next falling edge.
  task automatic drive(input wb_ctrl c, input logic last);
    wb_ctrl_i = c;
    is_last_in_block_i = last;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wb_ctrl_i = '0;
    is_last_in_block_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    blocked = 0;
    model_llbit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_ctrl_i = '0;
    is_last_in_block_i = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++; if ({reg_we_o, llbit_o, csr_we_o, excp_o, flush_o, refetch_o, block_commit_o, busy_o} !== 8'h00) begin
      failures++; $display("FAIL reset.flags got=%b exp=00000000", {reg_we_o, llbit_o, csr_we_o, excp_o, flush_o, refetch_o, block_commit_o, busy_o}); end
    checks++; if ({reg_waddr_o, reg_wdata_o, excp_ecode_o, excp_pc_o, refetch_pc_o} !== '0) begin
      failures++; $display("FAIL reset.data got=%h exp=0", {reg_waddr_o, reg_wdata_o, excp_ecode_o, excp_pc_o, refetch_pc_o}); end
    checks++; if (state_dbg_o !== 2'd0) begin failures++; $display("FAIL reset.state got=%0d exp=0", state_dbg_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    blocked = 0;
    model_llbit = 1'b0;
  endtask

  task automatic test_reg_commit();
    wb_ctrl c;
    c = mk_commit(32'h1c000000);
    c.wb_reg_o = '{we: 1'b1, waddr: 5'd5, wdata: 32'hDEAD};
    drive(c, 1'b1);
    checks++; if (reg_we_o !== 1'b1) begin failures++; $display("FAIL reg_commit.we got=%b exp=1", reg_we_o); end
    checks++; if (reg_waddr_o !== 5'd5) begin failures++; $display("FAIL reg_commit.waddr got=%0d exp=5", reg_waddr_o); end
    checks++; if (reg_wdata_o !== 32'hDEAD) begin failures++; $display("FAIL reg_commit.wdata got=%h exp=dead", reg_wdata_o); end
    checks++; if (flush_o !== 1'b0 || excp_o !== 1'b0) begin failures++; $display("FAIL reg_commit.noflush got=%b%b exp=00", flush_o, excp_o); end
    checks++; if (block_commit_o !== 1'b1) begin failures++; $display("FAIL reg_commit.block got=%b exp=1", block_commit_o); end
    idle(1);
    checks++; if (reg_we_o !== 1'b0 || block_commit_o !== 1'b0) begin failures++; $display("FAIL reg_commit.pulse got=%b%b exp=00", reg_we_o, block_commit_o); end
  endtask

  task automatic test_llbit_excp();
    wb_ctrl c;
    c = mk_commit(32'h1c000010);
    c.llbit_o = '{we: 1'b1, value: 1'b1};
    drive(c, 1'b0);
    checks++; if (llbit_o !== 1'b1) begin failures++; $display("FAIL llbit.set got=%b exp=1", llbit_o); end
    c = mk_commit(32'h1c000014);
    c.excp = 1'b1;
    c.excp_num = 16'h0010;
    c.wb_reg_o = '{we: 1'b1, waddr: 5'd9, wdata: 32'h1};
    drive(c, 1'b1);
    checks++; if (excp_o !== 1'b1) begin failures++; $display("FAIL llbit_excp.excp got=%b exp=1", excp_o); end
    checks++; if (excp_ecode_o !== EXCP_ECODE[4]) begin failures++; $display("FAIL llbit_excp.ecode got=%h exp=%h", excp_ecode_o, EXCP_ECODE[4]); end
    checks++; if (excp_pc_o !== 32'h1c000014) begin failures++; $display("FAIL llbit_excp.pc got=%h exp=1c000014", excp_pc_o); end
    checks++; if (llbit_o !== 1'b0 || reg_we_o !== 1'b0) begin failures++; $display("FAIL llbit_excp.nowrite got=%b%b exp=00", llbit_o, reg_we_o); end
    checks++; if (flush_o !== 1'b1) begin failures++; $display("FAIL llbit_excp.flush1 got=%b exp=1", flush_o); end
    idle(1);
    checks++; if (flush_o !== 1'b1 || excp_o !== 1'b0) begin failures++; $display("FAIL llbit_excp.flush2 got=%b%b exp=10", flush_o, excp_o); end
    idle(1);
    checks++; if (flush_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL llbit_excp.drain got=%b%b exp=01", flush_o, busy_o); end
    idle(1);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL llbit_excp.idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_excp_prio();
    wb_ctrl c;
    c = mk_commit(32'h1c000020);
    c.excp = 1'b1;
    c.excp_num = 16'h8001;
    drive(c, 1'b0);
    checks++; if (excp_ecode_o !== EXCP_ECODE[0] || excp_o !== 1'b1) begin failures++; $display("FAIL prio.8001 got=%h exp=%h", excp_ecode_o, EXCP_ECODE[0]); end
    idle(3);
    c.excp_num = 16'h0000;
    drive(c, 1'b0);
    checks++; if (excp_ecode_o !== 6'h3F || excp_o !== 1'b1) begin failures++; $display("FAIL prio.internal got=%h exp=3f", excp_ecode_o); end
    idle(3);
  endtask

  task automatic test_refetch();
    wb_ctrl c;
    c = mk_commit(32'hFFFFFFFC);
    c.fetch_flush = 1'b1;
    c.wb_reg_o = '{we: 1'b1, waddr: 5'd7, wdata: 32'h1234};
    drive(c, 1'b0);
    checks++; if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd7) begin failures++; $display("FAIL refetch.reg got=%b/%0d exp=1/7", reg_we_o, reg_waddr_o); end
    checks++; if (refetch_o !== 1'b1) begin failures++; $display("FAIL refetch.pulse got=%b exp=1", refetch_o); end
    checks++; if (refetch_pc_o !== 32'h0) begin failures++; $display("FAIL refetch.pc got=%h exp=0", refetch_pc_o); end
    c = mk_commit(32'h1c000100);
    c.wb_reg_o = '{we: 1'b1, waddr: 5'd3, wdata: 32'h55};
    for (int i = 0; i < FLUSH_CYCLES + 1; i++) begin
      drive(c, 1'b1);
      checks++; if (reg_we_o !== 1'b0 || refetch_o !== 1'b0 || block_commit_o !== 1'b0) begin
        failures++; $display("FAIL refetch.ignored[%0d] got=%b%b%b exp=000", i, reg_we_o, refetch_o, block_commit_o); end
    end
    drive(c, 1'b1);
    checks++; if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd3) begin failures++; $display("FAIL refetch.resume got=%b/%0d exp=1/3", reg_we_o, reg_waddr_o); end
    idle(1);
  endtask

  task automatic test_excp_refetch_reset();
    wb_ctrl c;
    c = mk_commit(32'h1c000200);
    c.excp = 1'b1;
    c.excp_num = 16'h0100;
    c.fetch_flush = 1'b1;
    drive(c, 1'b0);
    checks++; if (excp_o !== 1'b1 || refetch_o !== 1'b0) begin failures++; $display("FAIL both.excp_wins got=%b%b exp=10", excp_o, refetch_o); end
    checks++; if (excp_ecode_o !== EXCP_ECODE[8]) begin failures++; $display("FAIL both.ecode got=%h exp=%h", excp_ecode_o, EXCP_ECODE[8]); end
    wb_ctrl_i = '0;
    #2 rst = 1'b0;
    #1;
    checks++; if ({excp_o, flush_o, busy_o, refetch_o, reg_we_o, llbit_o} !== 6'b0 || state_dbg_o !== 2'd0) begin
      failures++; $display("FAIL both.reset_mid_flush got=%b st=%0d exp=0", {excp_o, flush_o, busy_o, refetch_o, reg_we_o, llbit_o}, state_dbg_o); end
    @(negedge clk);
    rst = 1'b1;
    c = mk_commit(32'h1c000300);
    c.wb_reg_o = '{we: 1'b1, waddr: 5'd11, wdata: 32'hBEEF};
    drive(c, 1'b0);
    checks++; if (reg_we_o !== 1'b1 || reg_wdata_o !== 32'hBEEF || flush_o !== 1'b0) begin
      failures++; $display("FAIL both.after_reset got=%b/%h/%b exp=1/beef/0", reg_we_o, reg_wdata_o, flush_o); end
    idle(1);
  endtask

  task automatic test_random();
    wb_ctrl c;
    logic last, acc, ex, rf, nw;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      c = '0;
      c.valid = ($urandom_range(0, 3) != 0);
      c.diff_commit_o.valid = ($urandom_range(0, 7) != 0);
      c.pc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
      c.excp = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: c.excp_num = 16'h0;
        1: c.excp_num = 16'h1 << $urandom_range(0, 15);
        default: c.excp_num = 16'($urandom());
      endcase
      c.fetch_flush = ($urandom_range(0, 9) == 0);
      c.wb_reg_o = '{we: 1'($urandom()), waddr: 5'($urandom()), wdata: $urandom()};
      c.llbit_o = '{we: 1'($urandom()), value: 1'($urandom())};
      c.csr_signal_o = '{we: 1'($urandom()), addr: 14'($urandom()), data: $urandom()};
      last = 1'($urandom());
      acc = (blocked == 0) && c.valid && c.diff_commit_o.valid;
      ex = acc && c.excp;
      rf = acc && c.fetch_flush && !c.excp;
      nw = acc && !c.excp;
      if (ex) model_llbit = 1'b0;
      else if (nw && c.llbit_o.we) model_llbit = c.llbit_o.value;
      blocked = (ex || rf) ? FLUSH_CYCLES + 1 : ((blocked > 0) ? blocked - 1 : 0);
      drive(c, last);
      checks++; if (reg_we_o !== (nw && c.wb_reg_o.we)) begin failures++; $display("FAIL rand[%0d].reg_we got=%b exp=%b", n, reg_we_o, nw && c.wb_reg_o.we); end
      if (nw && c.wb_reg_o.we) begin
        checks++; if ({reg_waddr_o, reg_wdata_o} !== {c.wb_reg_o.waddr, c.wb_reg_o.wdata}) begin
          failures++; $display("FAIL rand[%0d].reg_data got=%h exp=%h", n, {reg_waddr_o, reg_wdata_o}, {c.wb_reg_o.waddr, c.wb_reg_o.wdata}); end
      end
      checks++; if (csr_we_o !== (nw && c.csr_signal_o.we)) begin failures++; $display("FAIL rand[%0d].csr_we got=%b exp=%b", n, csr_we_o, nw && c.csr_signal_o.we); end
      if (nw) begin
        checks++; if (csr_signal_o !== c.csr_signal_o) begin failures++; $display("FAIL rand[%0d].csr_sig got=%h exp=%h", n, csr_signal_o, c.csr_signal_o); end
      end
      checks++; if (llbit_o !== model_llbit) begin failures++; $display("FAIL rand[%0d].llbit got=%b exp=%b", n, llbit_o, model_llbit); end
      checks++; if (excp_o !== ex || refetch_o !== rf) begin failures++; $display("FAIL rand[%0d].pulses got=%b%b exp=%b%b", n, excp_o, refetch_o, ex, rf); end
      if (ex) begin
        checks++; if (excp_ecode_o !== ref_ecode(c.excp_num) || excp_pc_o !== c.pc) begin
          failures++; $display("FAIL rand[%0d].excp got=%h/%h exp=%h/%h", n, excp_ecode_o, excp_pc_o, ref_ecode(c.excp_num), c.pc); end
      end
      if (rf) begin
        checks++; if (refetch_pc_o !== c.pc + 32'd4) begin failures++; $display("FAIL rand[%0d].refetch_pc got=%h exp=%h", n, refetch_pc_o, c.pc + 32'd4); end
      end
      checks++; if (block_commit_o !== (nw && !c.fetch_flush && last)) begin
        failures++; $display("FAIL rand[%0d].block got=%b exp=%b", n, block_commit_o, nw && !c.fetch_flush && last); end
      checks++; if (flush_o !== (blocked > 1) || busy_o !== (blocked > 0)) begin
        failures++; $display("FAIL rand[%0d].flush_busy got=%b%b exp=%b%b", n, flush_o, busy_o, blocked > 1, blocked > 0); end
    end
    idle(FLUSH_CYCLES + 1);
  endtask

`ifdef DIFFTEST_COMMIT_EN
  task automatic test_difftest();
    wb_ctrl c;
    longint cyc;
    do_reset();
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      c = mk_commit(32'h1c001000 + 32'(k * 4));
      c.diff_commit_o.instr = 32'h02800000 + 32'(k);
      if (k == 3 || k == 7) begin
        c.excp = 1'b1;
        c.excp_num = 16'h0002;
      end
      drive(c, 1'b0);
      cyc++;
      if (k == 0) begin
        checks++; if (diff_valid_o !== 1'b1 || diff_pc_o !== 32'h1c001000 || diff_instr_o !== 32'h02800000) begin
          failures++; $display("FAIL diff.first got=%b/%h/%h exp=1/1c001000/02800000", diff_valid_o, diff_pc_o, diff_instr_o); end
      end
      if (c.excp) begin
        checks++; if (diff_excp_o !== 1'b1 || diff_valid_o !== 1'b0 || diff_ecode_o !== EXCP_ECODE[1]) begin
          failures++; $display("FAIL diff.excp[%0d] got=%b%b/%h exp=10/%h", k, diff_excp_o, diff_valid_o, diff_ecode_o, EXCP_ECODE[1]); end
        idle(FLUSH_CYCLES + 1);
        cyc += FLUSH_CYCLES + 1;
      end
    end
    checks++; if (instret_o !== 64'd8) begin failures++; $display("FAIL diff.instret got=%0d exp=8", instret_o); end
    checks++; if (cycle_cnt_o !== 64'(cyc)) begin failures++; $display("FAIL diff.cycles got=%0d exp=%0d", cycle_cnt_o, cyc); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    blocked = 0;
    model_llbit = 1'b0;
    test_reset();
    test_reg_commit();
    test_llbit_excp();
    test_excp_prio();
    test_refetch();
    test_excp_refetch_reset();
    test_random();
`ifdef DIFFTEST_COMMIT_EN
    test_difftest();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
